// File: rtl/rs_flag_ctrl.sv
// rs_flag_ctrl: sequences set/reset pulses onto a bank of external RS latches.
// Optional FLAG_VERIFY_EN adds a sticky err flag that checks latch_q after each command.
module rs_flag_ctrl #(
  parameter int N_FLAGS = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [$clog2(N_FLAGS)-1:0] req_idx,
  input  logic                       req_op,
  output logic [N_FLAGS-1:0]         latch_s,
  output logic [N_FLAGS-1:0]         latch_r,
  input  logic [N_FLAGS-1:0]         latch_q,
`ifdef FLAG_VERIFY_EN
  output logic                       err,
`endif
  output logic                       done
);

  localparam logic [3:0] PW_M1 = 4'(PULSE_W - 1);
  localparam logic [3:0] GW_M1 = (GAP_W > 0) ? 4'(GAP_W - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [N_FLAGS-1:0]   r_latch_s;
  logic [N_FLAGS-1:0]   r_latch_r;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_hit;
  logic [N_FLAGS-1:0]   w_sel;

  assign req_ready = (r_state == S_IDLE) & ~reset;
  assign w_accept  = req_valid & req_ready;
  assign w_hit     = (latch_q[req_idx] == req_op);
  assign w_sel     = N_FLAGS'(1) << req_idx;

  assign latch_s = r_latch_s;
  assign latch_r = r_latch_r;
  assign done    = r_done;

  // Main sequencer: accept, pulse the selected latch, recover, report done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_latch_s <= '0;
      r_latch_r <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (!w_hit) begin
              r_state   <= S_PULSE;
              r_cnt     <= PW_M1;
              r_latch_s <= req_op ? w_sel : '0;
              r_latch_r <= req_op ? '0 : w_sel;
            end else begin
              r_state <= S_GAP;
              r_cnt   <= GW_M1;
            end
          end
        end
        S_PULSE: begin
          if (r_cnt == 4'd0) begin
            r_latch_s <= '0;
            r_latch_r <= '0;
            if (GAP_W == 0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_GAP;
              r_cnt   <= GW_M1;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_latch_s <= '0;
          r_latch_r <= '0;
        end
      endcase
    end
  end

`ifdef FLAG_VERIFY_EN
  logic [$clog2(N_FLAGS)-1:0] r_idx;
  logic                       r_op;
  logic                       r_err;
  logic                       w_check;

  // The latch should have settled by the final cycle of the command.
  assign w_check = (r_cnt == 4'd0) &&
                   ((r_state == S_GAP) ||
                    ((GAP_W == 0) && (r_state == S_PULSE)));

  assign err = r_err;

  // Capture the command target and latch a sticky error on bad feedback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx <= '0;
      r_op  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx <= req_idx;
        r_op  <= req_op;
      end
      if (w_check && (latch_q[r_idx] != r_op)) begin
        r_err <= 1'b1;
      end
    end
  end
`endif

endmodule
